down_counter: RTL

Loadable N-bit down-counter/timer that counts a programmed value down to zero and flags terminal count. It pairs with `up_counter` as the counting-down end of the same counter family. It is used as a reloadable interval timer: software or an FSM loads a period, the block decrements on each enabled clock, and it emits a one-cycle `tc` pulse on expiry.

---
 rtl/down_counter.sv | 86 ++++++++
 1 files changed

// File: rtl/down_counter.sv
// Loadable N-bit down-counter / interval timer with one-shot and auto-reload modes.
// Emits a single-cycle tc pulse on expiry; out is count delayed by one clock.
module down_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         auto,
    input  logic         stop,
    output logic [N-1:0] count,
    output logic [N-1:0] out,
    output logic         tc,
    output logic         busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t       state, state_nxt;
    logic [N-1:0] reload_val, reload_nxt;
    logic [N-1:0] count_nxt;
    logic         tc_nxt;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and datapath decode; load beats stop beats counting
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_val;
        tc_nxt     = 1'b0;
        if (load) begin
            count_nxt  = load_val;
            reload_nxt = load_val;
            state_nxt  = (load_val != '0) ? RUN : IDLE;
        end else if (stop) begin
            state_nxt  = IDLE;
        end else if (state == RUN && en) begin
            if (count > ONE) begin
                count_nxt = count - ONE;
            end else if (count == ONE) begin
                tc_nxt = 1'b1;
                if (auto) begin
                    count_nxt = reload_val;
                end else begin
                    count_nxt = '0;
                    state_nxt = IDLE;
                end
            end else begin
                // count==0 cannot occur in RUN; park safely rather than wrap
                state_nxt = IDLE;
            end
        end
    end

    // Outputs derived from the registered state
    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            out        <= '0;
            tc         <= 1'b0;
            reload_val <= '0;
        end else begin
            count      <= count_nxt;
            out        <= count;
            tc         <= tc_nxt;
            reload_val <= reload_nxt;
        end
    end

endmodule
